ifetch_queue: RTL
=================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter ADDR_BITS, default 32, sets PC and instruction-memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, sets instruction word width.
REQ-003 Parameter FIFO_DEPTH, default 4, sets prefetch-queue entries; it SHALL be a power of two and at least 2.
REQ-004 Parameter PC_STEP, default 4, sets the sequential PC increment.
REQ-005 Parameter RESET_PC, default 0, sets the PC value loaded at reset.
REQ-006 Port clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset_n  in  1  is the asynchronous, active-low reset.
REQ-008 Port redirect  in  1  is the branch/jump taken pulse.
REQ-009 Port redirect_pc  in  ADDR_BITS  is the redirect target, sampled when redirect=1.
REQ-010 Port imem_req  out  1  is the instruction-memory read strobe.
REQ-011 Port imem_addr  out  ADDR_BITS  is the instruction-memory read address.
REQ-012 Port imem_rdata  in  DATA_WIDTH  is the read data, valid exactly one cycle after imem_req.
REQ-013 Port out_valid  out  1  indicates the queue head holds an instruction.
REQ-014 Port out_ready  in  1  indicates decode accepts the head.
REQ-015 Port out_instr  out  DATA_WIDTH  is the head instruction.
REQ-016 Port out_pc  out  ADDR_BITS  is the head instruction's PC.
REQ-017 Port out_next_pc  out  ADDR_BITS  is out_pc + PC_STEP.
REQ-018 Port count  out  log2(FIFO_DEPTH)+1  is the current queue occupancy.

Function
REQ-019 imem_req SHALL be 1 when redirect=0 and count + inflight - pop < FIFO_DEPTH. Here inflight = last cycle's imem_req not killed by redirect, and pop = out_valid & out_ready.
REQ-020 imem_addr SHALL equal the fetch PC register; on each issued request, fetch PC SHALL advance by PC_STEP, wrapping modulo 2^ADDR_BITS.
REQ-021 A response SHALL be written to the queue in the cycle after its request, tagged with the request address.
REQ-022 Request-to-out_valid latency SHALL be 2 cycles: request in cycle N, write at the end of N+1, visible in N+2.
REQ-023 out_valid SHALL equal (count != 0); out_instr, out_pc and out_next_pc SHALL be driven from the queue head.
REQ-024 A pop SHALL occur when out_valid & out_ready; a simultaneous push and pop SHALL leave count unchanged.
REQ-025 The queue SHALL never overflow; a push when full is a design error, flagged by an assertion.
REQ-026 On redirect=1, the block SHALL, in the same edge: load fetch PC with redirect_pc, clear the queue (count=0), kill the inflight response, and hold imem_req=0 that cycle.
REQ-027 Redirect SHALL take priority over push, pop and issue in the same cycle; out_ready in a redirect cycle SHALL still pop the currently visible head.
REQ-028 The first request after a redirect SHALL issue the following cycle with imem_addr=redirect_pc.
REQ-029 Back-to-back redirects SHALL each take effect; only the last target SHALL be fetched.
REQ-030 With out_ready held at 1 and no redirect, steady-state throughput SHALL be one instruction per cycle.

Reset
REQ-031 While reset_n=0: fetch PC=RESET_PC, count=0, inflight=0, queue pointers=0, out_valid=0, imem_req=0.
REQ-032 Reset assertion SHALL take effect immediately, mid-operation, discarding queued and inflight data; queue storage contents need not reset.
REQ-033 The first cycle after reset_n rises SHALL assert imem_req with imem_addr=RESET_PC.

Structure
REQ-034 Shared package SHALL hold the default ADDR_BITS, DATA_WIDTH, PC_STEP and RESET_PC constants and the queue entry type {pc, instr}.
REQ-035 Queue storage and pointers SHALL live in one sub-module, fetch_fifo, with push, pop, clear, count, head outputs.

Verification
REQ-036 Reset then out_ready=1, imem returns addr>>2 -> imem_addr 0,4,8,... from cycle 1; out_pc=0 in cycle 3, then one instruction per cycle.
REQ-037 out_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 requests issued, count=4, imem_req=0; then ready=1 -> pops resume with no gap or loss.
REQ-038 redirect=1 with redirect_pc=0x100 while queue holds 3 entries -> next cycle count=0, imem_addr=0x100; first out_pc=0x100 two cycles later; the killed response is never visible.
REQ-039 Redirects to 0x200 then 0x300 in consecutive cycles -> no instruction from 0x200 is visible; out_pc sequence begins 0x300, 0x304.
REQ-040 RESET_PC=0xFFFFFFF8 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0; out_next_pc of the last entry = 0x4.
REQ-041 reset_n pulsed low with count=3 -> out_valid=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared defaults and the prefetch-queue entry type for the instruction fetch
// queue.
package ifetch_queue_pkg;

  localparam int DEF_ADDR_BITS  = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PC_STEP    = 4;
  localparam logic [DEF_ADDR_BITS-1:0] DEF_RESET_PC = '0;

  // One prefetched instruction tagged with the address it was fetched from.
  typedef struct packed {
    logic [DEF_ADDR_BITS-1:0]  pc;
    logic [DEF_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Power-of-two circular prefetch queue with a synchronous clear that beats
// both push and pop.
module fetch_fifo #(
  parameter  int WIDTH    = 64,
  parameter  int DEPTH    = 4,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_BITS + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  input  logic                clear,
  output logic [CNT_BITS-1:0] count,
  output logic [WIDTH-1:0]    head
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & (count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
    end
  end

  // NOTE: storage is deliberately left out of reset; count gates visibility,
  // so stale words are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(do_push && !do_pop && count == CNT_BITS'(DEPTH)));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetcher: issues sequential fetches while queue space is
// guaranteed, queues tagged responses, and flushes everything on redirect.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter  int ADDR_BITS  = DEF_ADDR_BITS,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int FIFO_DEPTH = 4,
  parameter  int PC_STEP    = DEF_PC_STEP,
  parameter  logic [ADDR_BITS-1:0] RESET_PC = ADDR_BITS'(DEF_RESET_PC),
  localparam int CNT_BITS   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  redirect,
  input  logic [ADDR_BITS-1:0]  redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_BITS-1:0]  imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_BITS-1:0]  out_pc,
  output logic [ADDR_BITS-1:0]  out_next_pc,
  output logic [CNT_BITS-1:0]   count
);

  typedef struct packed {
    logic [ADDR_BITS-1:0]  pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ifetch_queue: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_BITS-1:0] fetch_pc;
  logic [ADDR_BITS-1:0] inflight_pc;
  logic                 inflight;
  logic                 pop;
  logic                 push;
  logic [CNT_BITS-1:0]  occupancy;
  entry_t               push_entry;
  entry_t               head;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // Slots committed once this cycle settles; an inflight response always owns
  // a slot, so the queue can never be pushed while full.
  assign occupancy = count + CNT_BITS'(inflight) - CNT_BITS'(pop);

  // NOTE: reset_n gates the strobe combinationally so no request leaks out
  // while reset is held, yet the first cycle after release issues at once.
  assign imem_req  = reset_n & ~redirect & (occupancy < CNT_BITS'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;

  assign push       = inflight & ~redirect;
  assign push_entry = '{pc: inflight_pc, instr: imem_rdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) inflight_pc <= fetch_pc;
      if (redirect)      fetch_pc <= redirect_pc;
      else if (imem_req) fetch_pc <= fetch_pc + ADDR_BITS'(PC_STEP);
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_BITS + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect),
    .count     (count),
    .head      (head)
  );

  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign out_next_pc = head.pc + ADDR_BITS'(PC_STEP);

endmodule
